// File: rtl/servo_array_driver.sv
// N-channel servo PWM driver. One shared prescaler and frame counter feed all channels.
// Each channel is positioned by buttons or a ping-pong sweep, clamped to per-channel and global limits.
module servo_array_driver #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned PERIOD_TICKS = 20000,
  parameter int unsigned PW_MIN       = 500,
  parameter int unsigned PW_MAX       = 2500,
  parameter int unsigned PW_RESET     = 1500,
  parameter int unsigned STEP         = 10
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS-1:0]       BTN_0,
  input  logic [CHANNELS-1:0]       BTN_1,
  input  logic [CHANNELS-1:0]       ES,
  input  logic [CHANNELS*WIDTH-1:0] pulseWidth_max,
  output logic [CHANNELS-1:0]       SERVO,
  output logic [CHANNELS*WIDTH-1:0] servo_position,
  output logic [CHANNELS-1:0]       PWM_limit,
  output logic [CHANNELS-1:0]       PWM_floor,
  output logic [2*CHANNELS-1:0]     direction,
  output logic                      frame_start
);

  localparam int unsigned PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FCW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int unsigned EW  = WIDTH + 1;
  localparam int unsigned CW  = ((FCW > WIDTH) ? FCW : WIDTH) + 1;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_CCW  = 2'b01;
  localparam logic [1:0] DIR_CW   = 2'b10;

  localparam logic [EW-1:0] MIN_E  = EW'(PW_MIN);
  localparam logic [EW-1:0] MAX_E  = EW'(PW_MAX);
  localparam logic [EW-1:0] RST_E  = EW'(PW_RESET);
  localparam logic [EW-1:0] STEP_E = EW'(STEP);

  logic [PSW-1:0] presc_q;
  logic [FCW-1:0] frame_q;
  logic           tick;
  logic           frame_end;

  logic [EW-1:0] pos_q   [CHANNELS];
  logic [EW-1:0] pos_d   [CHANNELS];
  logic [EW-1:0] eff_q   [CHANNELS];
  logic [EW-1:0] eff_d   [CHANNELS];
  logic [EW-1:0] eff_now [CHANNELS];
  logic [1:0]    dir_q   [CHANNELS];
  logic [1:0]    dir_d   [CHANNELS];
  logic [1:0]    sweep_q [CHANNELS];
  logic [1:0]    sweep_d [CHANNELS];

  assign tick      = (presc_q == PSW'(CLK_DIV - 1));
  assign frame_end = tick && (frame_q == FCW'(PERIOD_TICKS - 1));

  // Shared timebase: prescaler and frame counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q <= '0;
      frame_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PSW'(1);
      if (tick) begin
        frame_q <= frame_end ? '0 : frame_q + FCW'(1);
      end
    end
  end

  // Per-channel next state: direction source, clamped position step, sweep reversal.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pos_d[i]   = pos_q[i];
      eff_d[i]   = eff_q[i];
      sweep_d[i] = sweep_q[i];
      dir_d[i]   = DIR_STOP;

      eff_now[i] = {1'b0, pulseWidth_max[i*WIDTH +: WIDTH]};
      if (eff_now[i] > MAX_E) eff_now[i] = MAX_E;
      if (eff_now[i] < MIN_E) eff_now[i] = MIN_E;

      if (ES[i]) begin
        dir_d[i] = sweep_q[i];
      end else begin
        case ({BTN_1[i], BTN_0[i]})
          2'b01:   dir_d[i] = DIR_CCW;
          2'b10:   dir_d[i] = DIR_CW;
          default: dir_d[i] = DIR_STOP;
        endcase
      end

      if (frame_end) begin
        eff_d[i] = eff_now[i];
        if (eff_now[i] < pos_q[i]) begin
          pos_d[i] = eff_now[i];
        end else begin
          case (dir_q[i])
            DIR_CCW: pos_d[i] = (pos_q[i] + STEP_E > eff_now[i]) ? eff_now[i] : pos_q[i] + STEP_E;
            DIR_CW:  pos_d[i] = (pos_q[i] < MIN_E + STEP_E) ? MIN_E : pos_q[i] - STEP_E;
            default: pos_d[i] = pos_q[i];
          endcase
        end
        // Floor check last so a degenerate eff_max == PW_MIN keeps sweeping up.
        if (ES[i]) begin
          if (pos_d[i] >= eff_now[i]) sweep_d[i] = DIR_CW;
          if (pos_d[i] <= MIN_E)      sweep_d[i] = DIR_CCW;
        end
      end
    end
  end

  // Channel state and registered status/PWM outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pos_q[i]   <= RST_E;
        eff_q[i]   <= MAX_E;
        dir_q[i]   <= DIR_STOP;
        sweep_q[i] <= DIR_CCW;
      end
      SERVO       <= '0;
      PWM_limit   <= '0;
      PWM_floor   <= '0;
      frame_start <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pos_q[i]     <= pos_d[i];
        eff_q[i]     <= eff_d[i];
        dir_q[i]     <= dir_d[i];
        sweep_q[i]   <= sweep_d[i];
        SERVO[i]     <= (CW'(frame_q) < CW'(pos_q[i]));
        PWM_limit[i] <= (pos_q[i] >= eff_q[i]);
        PWM_floor[i] <= (pos_q[i] == MIN_E);
      end
      frame_start <= (frame_q == '0) && (presc_q == '0);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign servo_position[g*WIDTH +: WIDTH] = pos_q[g][WIDTH-1:0];
    assign direction[2*g +: 2]              = dir_q[g];
  end

endmodule

// File: tb/tb_servo_array_driver.sv
// Bench for servo_array_driver: directed scenarios plus random stimulus,
// checked every cycle against a frame-arithmetic reference model.
module tb_servo_array_driver;

  localparam int unsigned CH    = 2;
  localparam int unsigned W     = 32;
  localparam int unsigned DIV   = 2;
  localparam int unsigned PER   = 100;
  localparam int unsigned PMIN  = 10;
  localparam int unsigned PMAX  = 70;
  localparam int unsigned PRST  = 40;
  localparam int unsigned STP   = 5;
  localparam int unsigned FRAME = DIV * PER;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [CH-1:0]   BTN_0 = '0;
  logic [CH-1:0]   BTN_1 = '0;
  logic [CH-1:0]   ES = '0;
  logic [CH*W-1:0] pulseWidth_max = '0;
  logic [CH-1:0]   SERVO;
  logic [CH*W-1:0] servo_position;
  logic [CH-1:0]   PWM_limit;
  logic [CH-1:0]   PWM_floor;
  logic [2*CH-1:0] direction;
  logic            frame_start;

  always #5 CLK = ~CLK;

  servo_array_driver #(
    .CHANNELS(CH), .WIDTH(W), .CLK_DIV(DIV), .PERIOD_TICKS(PER),
    .PW_MIN(PMIN), .PW_MAX(PMAX), .PW_RESET(PRST), .STEP(STP)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_0(BTN_0), .BTN_1(BTN_1), .ES(ES),
    .pulseWidth_max(pulseWidth_max), .SERVO(SERVO), .servo_position(servo_position),
    .PWM_limit(PWM_limit), .PWM_floor(PWM_floor), .direction(direction),
    .frame_start(frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: n counts CLK edges since reset release; phase = n % FRAME.
  longint unsigned n;
  longint unsigned m_pos  [CH];
  longint unsigned m_effq [CH];
  logic [1:0]      m_sweep[CH];
  logic [1:0]      e_dir  [CH];
  logic [CH-1:0]   e_servo, e_lim, e_floor;
  logic            e_fs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = PRST; m_effq[i] = PMAX; m_sweep[i] = 2'b01; e_dir[i] = 2'b00;
    end
    e_servo = '0; e_lim = '0; e_floor = '0; e_fs = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] nd[CH];
    longint unsigned ph, eff;
    ph = n % FRAME;
    for (int i = 0; i < CH; i++) begin
      e_servo[i] = (ph < m_pos[i] * DIV);
      e_lim[i]   = (m_pos[i] >= m_effq[i]);
      e_floor[i] = (m_pos[i] == PMIN);
      if (ES[i])                  nd[i] = m_sweep[i];
      else if (BTN_0[i] && !BTN_1[i]) nd[i] = 2'b01;
      else if (BTN_1[i] && !BTN_0[i]) nd[i] = 2'b10;
      else                        nd[i] = 2'b00;
    end
    e_fs = (ph == 0);
    if (ph == FRAME - 1) begin
      for (int i = 0; i < CH; i++) begin
        eff = longint'(pulseWidth_max[i*W +: W]);
        if (eff > PMAX) eff = PMAX;
        if (eff < PMIN) eff = PMIN;
        if (eff < m_pos[i])        m_pos[i] = eff;
        else if (e_dir[i] == 2'b01) m_pos[i] = (m_pos[i] + STP > eff) ? eff : m_pos[i] + STP;
        else if (e_dir[i] == 2'b10) m_pos[i] = (m_pos[i] < PMIN + STP) ? PMIN : m_pos[i] - STP;
        if (ES[i]) begin
          if (m_pos[i] >= eff)  m_sweep[i] = 2'b10;
          if (m_pos[i] <= PMIN) m_sweep[i] = 2'b01;
        end
        m_effq[i] = eff;
      end
    end
    for (int i = 0; i < CH; i++) e_dir[i] = nd[i];
    n++;
  endtask

  task automatic compare_all();
    logic [CH*W-1:0] ep;
    logic [2*CH-1:0] ed;
    for (int i = 0; i < CH; i++) begin
      ep[i*W +: W] = W'(m_pos[i]);
      ed[2*i +: 2] = e_dir[i];
    end
    check("SERVO", 64'(SERVO), 64'(e_servo));
    check("servo_position", 64'(servo_position), 64'(ep));
    check("PWM_limit", 64'(PWM_limit), 64'(e_lim));
    check("PWM_floor", 64'(PWM_floor), 64'(e_floor));
    check("direction", 64'(direction), 64'(ed));
    check("frame_start", 64'(frame_start), 64'(e_fs));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) model_reset();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) compare_all();
    end
  end

  task automatic set_max(input int ch, input longint unsigned v);
    pulseWidth_max[ch*W +: W] = W'(v);
  endtask

  function automatic int pos_of(input int ch);
    return int'(servo_position[ch*W +: W]);
  endfunction

  task automatic wait_fs();
    int k;
    k = 0;
    do begin @(negedge CLK); k++; end while (!frame_start && k < 400);
    if (!frame_start) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout actual=0 expected=1 at t=%0t", $time);
    end
  endtask

  task automatic measure_frame(output int hi0, output int hi1, output int len);
    hi0 = 0; hi1 = 0; len = 0;
    do begin
      hi0 += int'(SERVO[0]); hi1 += int'(SERVO[1]);
      @(negedge CLK); len++;
    end while (!frame_start && len < 400);
  endtask

  initial begin
    int hi0, hi1, len, p, pmax, pmin, toggles, k, r;
    logic [1:0] prev_dir;
    int up_seq[5]   = '{45, 50, 55, 60, 60};
    int down_seq[7] = '{35, 30, 25, 20, 15, 10, 10};

    set_max(0, 200); set_max(1, 200);
    repeat (3) @(negedge CLK);
    #1;
    check("rst_pos", 64'(servo_position), {32'd40, 32'd40});
    check("rst_servo", 64'(SERVO), 64'd0);
    check("rst_dir", 64'(direction), 64'd0);
    check("rst_limit_floor", 64'({PWM_limit, PWM_floor}), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    @(negedge CLK); RST = 1'b1;

    // Idle frame: 40 ticks high of a 200-CLK frame.
    wait_fs();
    measure_frame(hi0, hi1, len);
    check("idle_high0", 64'(hi0), 64'd80);
    check("idle_high1", 64'(hi1), 64'd80);
    check("idle_len", 64'(len), 64'd200);

    // Channel 0 up to its own max of 60.
    set_max(0, 60); BTN_0[0] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_fs();
      check("up_seq", 64'(pos_of(0)), 64'(up_seq[f]));
      if (f == 3) check("up_limit", 64'(PWM_limit[0]), 64'd1);
    end
    check("ch1_hold", 64'(pos_of(1)), 64'd40);

    // Max lowered below position.
    BTN_0[0] = 1'b0; set_max(0, 30);
    wait_fs();
    check("lowered_pos", 64'(pos_of(0)), 64'd30);
    check("lowered_limit", 64'(PWM_limit[0]), 64'd1);

    // Channel 1 down to floor.
    BTN_1[1] = 1'b1;
    for (int f = 0; f < 7; f++) begin
      wait_fs();
      check("down_seq", 64'(pos_of(1)), 64'(down_seq[f]));
    end
    check("down_floor", 64'(PWM_floor[1]), 64'd1);
    BTN_0[1] = 1'b1;
    @(negedge CLK);
    check("both_btn_dir", 64'(direction[3:2]), 64'd0);
    wait_fs(); wait_fs();
    check("both_btn_pos", 64'(pos_of(1)), 64'd10);
    BTN_0[1] = 1'b0; BTN_1[1] = 1'b0;

    // Sweep on channel 0: 30 -> 70 -> 10 -> 30 in 24 frames.
    ES[0] = 1'b1; set_max(0, 200);
    @(negedge CLK);
    check("sweep_src_switch", 64'(direction[1:0]), 64'd1);
    prev_dir = direction[1:0]; pmax = 0; pmin = 1000; toggles = 0;
    for (int f = 0; f < 24; f++) begin
      wait_fs();
      p = pos_of(0);
      if (p > pmax) pmax = p;
      if (p < pmin) pmin = p;
      if (direction[1:0] != prev_dir) toggles++;
      prev_dir = direction[1:0];
      if (p == 70) check("sweep_dir_top", 64'(direction[1:0]), 64'd2);
      if (p == 10) check("sweep_dir_floor", 64'(direction[1:0]), 64'd1);
    end
    check("sweep_max", 64'(pmax), 64'd70);
    check("sweep_min", 64'(pmin), 64'd10);
    check("sweep_toggles", 64'(toggles), 64'd2);
    check("sweep_end_pos", 64'(pos_of(0)), 64'd30);

    // Drive to 70, then reset mid-frame with SERVO high.
    ES[0] = 1'b0; BTN_0[0] = 1'b1;
    for (int f = 0; f < 9; f++) wait_fs();
    check("pre_reset_pos", 64'(pos_of(0)), 64'd70);
    repeat (100) @(negedge CLK);
    check("pre_reset_servo", 64'(SERVO[0]), 64'd1);
    #2 RST = 1'b0; BTN_0 = '0;
    #1;
    check("reset_servo_low", 64'(SERVO), 64'd0);
    check("reset_pos", 64'(servo_position), {32'd40, 32'd40});
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    k = 0;
    do begin @(negedge CLK); k++; end while (!frame_start && k < 400);
    check("release_first_fs", 64'(k), 64'd1);
    check("release_servo_rise", 64'(SERVO[0]), 64'd1);
    measure_frame(hi0, hi1, len);
    check("release_len", 64'(len), 64'd200);
    check("release_high0", 64'(hi0), 64'd80);

    // Random phase.
    for (int c = 0; c < 12000; c++) begin
      @(negedge CLK);
      r = int'($urandom_range(0, 999));
      if (r < 10)      BTN_0 = CH'($urandom);
      else if (r < 20) BTN_1 = CH'($urandom);
      else if (r < 24) ES = CH'($urandom);
      else if (r < 30) set_max(int'($urandom_range(0, 1)),
                               ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF : 64'($urandom_range(0, 90)));
      if (c == 6000) RST = 1'b0;
      if (c == 6003) RST = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
